// File: rtl/commit_pkg.sv
// Shared types and defaults for the pipe #6 writeback/commit stage.
package commit_pkg;

  typedef enum logic [2:0] {
    WB_ALU    = 3'd0,
    WB_LUI    = 3'd1,
    WB_AUIPC  = 3'd2,
    WB_LINK   = 3'd3,
    WB_LOAD   = 3'd4,
    WB_MULDIV = 3'd5
  } wb_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } commit_state_e;

  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam int          FLUSH_CYCLES_DEF = 3;

endpackage

// File: rtl/commit_stage_wb_mux.sv
// Writeback source select; purely combinational so the same value serves
// both the regfile write port and operand forwarding.
module wb_mux
  import commit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wb_sel_e         fn,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] uimm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mem,
  input  logic [XLEN-1:0] md,
  output logic [XLEN-1:0] wdata
);

  always_comb begin
    // NOTE: default assignment first so every path drives wdata and no latch is inferred.
    wdata = alu;
    case (fn)
      WB_LUI:    wdata = uimm;
      WB_AUIPC:  wdata = pc + uimm;
      WB_LINK:   wdata = pc + XLEN'(4);
      WB_LOAD:   wdata = mem;
      WB_MULDIV: wdata = md;
      default:   wdata = alu;
    endcase
  end

endmodule

// File: rtl/commit_stage.sv
// Pipe #6 commit stage: aligns execute results with load data, drives the
// regfile write port, traps misaligned accesses and counts retirements.
module commit_stage
  import commit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid5,
  input  logic            we5,
  input  logic [2:0]      fn5,
  input  logic [4:0]      rd5,
  input  logic [XLEN-1:0] alu_res5,
  input  logic [XLEN-1:0] U_imm5,
  input  logic [XLEN-1:0] pc5,
  input  logic [XLEN-1:0] mul_div5,
  input  logic [XLEN-1:0] mem_out6,
  input  logic            addr_misaligned6,
  output logic            rf_we6,
  output logic [4:0]      rf_waddr6,
  output logic [XLEN-1:0] rf_wdata6,
  output logic            trap6,
  output logic [XLEN-1:0] trap_pc6,
  output logic [XLEN-1:0] mepc6,
  output logic            flush6,
  output logic [63:0]     instret6
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic            valid6_q, valid6_d;
  logic            we6_q, we6_d;
  logic [2:0]      fn6_q, fn6_d;
  logic [4:0]      rd6_q, rd6_d;
  logic [XLEN-1:0] alu6_q, alu6_d;
  logic [XLEN-1:0] uimm6_q, uimm6_d;
  logic [XLEN-1:0] pc6_q, pc6_d;
  logic [XLEN-1:0] md6_q, md6_d;

  commit_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [63:0]     instret_q, instret_d;

  logic            in_run;
  logic            take_trap;
  logic            retire;

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .fn    (wb_sel_e'(fn6_q)),
    .alu   (alu6_q),
    .uimm  (uimm6_q),
    .pc    (pc6_q),
    .mem   (mem_out6),
    .md    (md6_q),
    .wdata (rf_wdata6)
  );

  assign in_run    = (state_q == RUN);
  assign take_trap = valid6_q & addr_misaligned6 & in_run;
  assign retire    = valid6_q & ~addr_misaligned6 & in_run;

  assign rf_we6    = valid6_q & we6_q & (rd6_q != 5'd0) & ~addr_misaligned6 & in_run;
  assign rf_waddr6 = rd6_q;
  assign trap6     = take_trap;
  assign trap_pc6  = TRAP_VECTOR;
  assign flush6    = take_trap | (state_q == TRAP);
  assign mepc6     = mepc_q;
  assign instret6  = instret_q;

  always_comb begin
    valid6_d = valid5 & ~flush6;
    we6_d    = we5;
    fn6_d    = fn5;
    rd6_d    = rd5;
    alu6_d   = alu_res5;
    uimm6_d  = U_imm5;
    pc6_d    = pc5;
    md6_d    = mul_div5;
  end

  // The trap cycle itself counts as the first flush cycle, so TRAP lasts
  // FLUSH_CYCLES-1 cycles and is skipped entirely when FLUSH_CYCLES is 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mepc_d    = mepc_q;
    instret_d = instret_q + 64'(retire);
    case (state_q)
      RUN: begin
        if (take_trap) begin
          mepc_d  = pc6_q;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = (FLUSH_CYCLES > 1) ? TRAP : RUN;
        end
      end
      TRAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid6_q  <= 1'b0;
      we6_q     <= 1'b0;
      fn6_q     <= '0;
      rd6_q     <= '0;
      alu6_q    <= '0;
      uimm6_q   <= '0;
      pc6_q     <= '0;
      md6_q     <= '0;
      state_q   <= RUN;
      cnt_q     <= '0;
      mepc_q    <= '0;
      instret_q <= '0;
    end else begin
      valid6_q  <= valid6_d;
      we6_q     <= we6_d;
      fn6_q     <= fn6_d;
      rd6_q     <= rd6_d;
      alu6_q    <= alu6_d;
      uimm6_q   <= uimm6_d;
      pc6_q     <= pc6_d;
      md6_q     <= md6_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mepc_q    <= mepc_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: writeback select, rd0, trap/flush,
// reset during flush and retired-instruction counter wrap.
module tb_commit_stage;
  import commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid5, we5;
  logic [2:0]  fn5;
  logic [4:0]  rd5;
  logic [31:0] alu_res5, U_imm5, pc5, mul_div5;
  logic [31:0] mem_out6;
  logic        addr_misaligned6;
  logic        rf_we6;
  logic [4:0]  rf_waddr6;
  logic [31:0] rf_wdata6;
  logic        trap6;
  logic [31:0] trap_pc6, mepc6;
  logic        flush6;
  logic [63:0] instret6;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] exp_instret;

  commit_stage dut (
    .clk              (clk),
    .rst              (rst),
    .valid5           (valid5),
    .we5              (we5),
    .fn5              (fn5),
    .rd5              (rd5),
    .alu_res5         (alu_res5),
    .U_imm5           (U_imm5),
    .pc5              (pc5),
    .mul_div5         (mul_div5),
    .mem_out6         (mem_out6),
    .addr_misaligned6 (addr_misaligned6),
    .rf_we6           (rf_we6),
    .rf_waddr6        (rf_waddr6),
    .rf_wdata6        (rf_wdata6),
    .trap6            (trap6),
    .trap_pc6         (trap_pc6),
    .mepc6            (mepc6),
    .flush6           (flush6),
    .instret6         (instret6)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "timeout");
  end

  task automatic drive5(input logic v, input logic we, input logic [2:0] fn,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] uimm, input logic [31:0] pc,
                        input logic [31:0] md);
    valid5 = v; we5 = we; fn5 = fn; rd5 = rd;
    alu_res5 = alu; U_imm5 = uimm; pc5 = pc; mul_div5 = md;
  endtask

  task automatic idle5();
    drive5(1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Advance one edge, then present the pipe #6 side inputs and let outputs settle.
  task automatic tick(input logic [31:0] mem, input logic mis);
    @(posedge clk);
    #1;
    mem_out6 = mem;
    addr_misaligned6 = mis;
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] fn, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] uimm,
                       input logic [31:0] pc, input logic [31:0] md,
                       input logic [31:0] mem, input logic mis);
    drive5(1'b1, we, fn, rd, alu, uimm, pc, md);
    tick(mem, mis);
    idle5();
  endtask

  task automatic test_reset();
    logic [63:0] got[8];
    logic [63:0] want[8];
    string       nm[8];
    rst = 1'b1;
    drive5(1'b1, 1'b1, WB_ALU, 5'd3, 32'hAAAA_AAAA, 32'h1, 32'h2, 32'h3);
    tick(32'hFFFF_FFFF, 1'b1);
    tick(32'hFFFF_FFFF, 1'b1);
    got[0] = 64'(rf_we6);    want[0] = 64'd0;     nm[0] = "reset_rf_we";
    got[1] = 64'(rf_waddr6); want[1] = 64'd0;     nm[1] = "reset_rf_waddr";
    got[2] = 64'(rf_wdata6); want[2] = 64'd0;     nm[2] = "reset_rf_wdata";
    got[3] = 64'(trap6);     want[3] = 64'd0;     nm[3] = "reset_trap";
    got[4] = 64'(trap_pc6);  want[4] = 64'h100;   nm[4] = "reset_trap_pc";
    got[5] = 64'(mepc6);     want[5] = 64'd0;     nm[5] = "reset_mepc";
    got[6] = 64'(flush6);    want[6] = 64'd0;     nm[6] = "reset_flush";
    got[7] = instret6;       want[7] = 64'd0;     nm[7] = "reset_instret";
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin
        n_mis++;
        $display("FAIL %s: got 0x%0h want 0x%0h", nm[i], got[i], want[i]);
      end
    end
    rst = 1'b0;
    idle5();
    tick(32'h0, 1'b0);
    exp_instret = 64'd0;
  endtask

  task automatic test_alu_write();
    issue(1'b1, WB_ALU, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we6 !== 1'b1) begin n_mis++; $display("FAIL alu_we: got %0b want 1", rf_we6); end
    n_cmp++; if (rf_waddr6 !== 5'd5) begin n_mis++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr6); end
    n_cmp++; if (rf_wdata6 !== 32'h1234) begin n_mis++; $display("FAIL alu_wdata: got 0x%0h want 0x1234", rf_wdata6); end
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL alu_instret_before: got %0d want %0d", instret6, exp_instret); end
    exp_instret++;
    tick(32'h0, 1'b0);
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL alu_instret_after: got %0d want %0d", instret6, exp_instret); end
    n_cmp++; if (rf_we6 !== 1'b0) begin n_mis++; $display("FAIL alu_idle_we: got %0b want 0", rf_we6); end
  endtask

  // Every select code with distinct values on each source so a wrong arm shows.
  task automatic test_wb_sources();
    logic [31:0] want[8];
    want[0] = 32'h1111_1111;  // ALU
    want[1] = 32'h2222_2000;  // LUI
    want[2] = 32'h2222_2300;  // AUIPC
    want[3] = 32'h0000_0304;  // LINK
    want[4] = 32'h5555_5555;  // LOAD
    want[5] = 32'h4444_4444;  // MULDIV
    want[6] = 32'h1111_1111;  // undefined code
    want[7] = 32'h1111_1111;  // undefined code
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 3'(i), 5'(8 + i), 32'h1111_1111, 32'h2222_2000, 32'h0000_0300,
            32'h4444_4444, 32'h5555_5555, 1'b0);
      n_cmp++;
      if (rf_wdata6 !== want[i]) begin
        n_mis++;
        $display("FAIL src_wdata fn=%0d: got 0x%0h want 0x%0h", i, rf_wdata6, want[i]);
      end
      n_cmp++;
      if (rf_we6 !== 1'b1 || rf_waddr6 !== 5'(8 + i)) begin
        n_mis++;
        $display("FAIL src_port fn=%0d: got we=%0b addr=%0d want we=1 addr=%0d", i, rf_we6, rf_waddr6, 8 + i);
      end
      n_cmp++;
      if (instret6 !== exp_instret) begin
        n_mis++;
        $display("FAIL src_instret fn=%0d: got %0d want %0d", i, instret6, exp_instret);
      end
      exp_instret++;
    end
  endtask

  task automatic test_rd0_links();
    issue(1'b1, WB_ALU, 5'd0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we6 !== 1'b0) begin n_mis++; $display("FAIL rd0_we: got %0b want 0", rf_we6); end
    n_cmp++; if (rf_wdata6 !== 32'h55) begin n_mis++; $display("FAIL rd0_wdata: got 0x%0h want 0x55", rf_wdata6); end
    exp_instret++;
    issue(1'b0, WB_ALU, 5'd6, 32'h66, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we6 !== 1'b0) begin n_mis++; $display("FAIL nowe_we: got %0b want 0", rf_we6); end
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL rd0_instret: got %0d want %0d", instret6, exp_instret); end
    exp_instret++;
    issue(1'b1, WB_LINK, 5'd1, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_wdata6 !== 32'h0) begin n_mis++; $display("FAIL link_wrap_wdata: got 0x%0h want 0x0", rf_wdata6); end
    n_cmp++; if (rf_we6 !== 1'b1) begin n_mis++; $display("FAIL link_we: got %0b want 1", rf_we6); end
    exp_instret++;
    issue(1'b1, WB_AUIPC, 5'd2, 32'h0, 32'h2000, 32'h100, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_wdata6 !== 32'h2100) begin n_mis++; $display("FAIL auipc_wdata: got 0x%0h want 0x2100", rf_wdata6); end
    exp_instret++;
  endtask

  task automatic test_load();
    issue(1'b1, WB_LOAD, 5'd7, 32'h0BAD, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    n_cmp++; if (rf_wdata6 !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL load_wdata: got 0x%0h want 0xdeadbeef", rf_wdata6); end
    n_cmp++; if (rf_we6 !== 1'b1 || rf_waddr6 !== 5'd7) begin n_mis++; $display("FAIL load_port: got we=%0b addr=%0d want we=1 addr=7", rf_we6, rf_waddr6); end
    exp_instret++;
    tick(32'h0, 1'b0);
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL load_instret: got %0d want %0d", instret6, exp_instret); end
  endtask

  // Trap cycle plus two TRAP cycles of flush while execute keeps presenting
  // a valid writer; it must only commit once the flush is over.
  task automatic test_back_to_back_trap();
    logic       mis_tab[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       flush_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       trap_tab[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       we_tab[5]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive5(1'b1, 1'b1, WB_LOAD, 5'd9, 32'h0, 32'h0, 32'h40, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick(32'h1, mis_tab[c]);
      if (c == 0) drive5(1'b1, 1'b1, WB_ALU, 5'd10, 32'h00C0_FFEE, 32'h0, 32'h200, 32'h0);
      n_cmp++;
      if (flush6 !== flush_tab[c]) begin n_mis++; $display("FAIL trap_flush c=%0d: got %0b want %0b", c, flush6, flush_tab[c]); end
      n_cmp++;
      if (trap6 !== trap_tab[c]) begin n_mis++; $display("FAIL trap_pulse c=%0d: got %0b want %0b", c, trap6, trap_tab[c]); end
      n_cmp++;
      if (rf_we6 !== we_tab[c]) begin n_mis++; $display("FAIL trap_we c=%0d: got %0b want %0b", c, rf_we6, we_tab[c]); end
      n_cmp++;
      if (instret6 !== exp_instret) begin n_mis++; $display("FAIL trap_instret c=%0d: got %0d want %0d", c, instret6, exp_instret); end
      if (c == 0) begin
        n_cmp++;
        if (trap_pc6 !== 32'h100) begin n_mis++; $display("FAIL trap_pc: got 0x%0h want 0x100", trap_pc6); end
      end
      if (c == 1) begin
        n_cmp++;
        if (mepc6 !== 32'h40) begin n_mis++; $display("FAIL trap_mepc: got 0x%0h want 0x40", mepc6); end
      end
      if (c == 4) begin
        n_cmp++;
        if (rf_waddr6 !== 5'd10 || rf_wdata6 !== 32'h00C0_FFEE) begin
          n_mis++;
          $display("FAIL trap_resume: got addr=%0d data=0x%0h want addr=10 data=0xc0ffee", rf_waddr6, rf_wdata6);
        end
        idle5();
        exp_instret++;
      end
    end
    tick(32'h0, 1'b0);
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL trap_resume_instret: got %0d want %0d", instret6, exp_instret); end
  endtask

  task automatic test_reset_mid_trap();
    drive5(1'b1, 1'b1, WB_LOAD, 5'd11, 32'h0, 32'h0, 32'h80, 32'h0);
    tick(32'h0, 1'b1);
    idle5();
    n_cmp++; if (trap6 !== 1'b1) begin n_mis++; $display("FAIL rmt_trap: got %0b want 1", trap6); end
    tick(32'h0, 1'b0);
    n_cmp++; if (flush6 !== 1'b1 || mepc6 !== 32'h80) begin n_mis++; $display("FAIL rmt_flush_pre: got flush=%0b mepc=0x%0h want flush=1 mepc=0x80", flush6, mepc6); end
    rst = 1'b1;
    drive5(1'b1, 1'b1, WB_ALU, 5'd12, 32'h1212, 32'h0, 32'h0, 32'h0);
    tick(32'h0, 1'b1);
    rst = 1'b0;
    idle5();
    exp_instret = 64'd0;
    n_cmp++; if (flush6 !== 1'b0) begin n_mis++; $display("FAIL rmt_flush: got %0b want 0", flush6); end
    n_cmp++; if (trap6 !== 1'b0 || rf_we6 !== 1'b0) begin n_mis++; $display("FAIL rmt_trap_we: got trap=%0b we=%0b want 0 0", trap6, rf_we6); end
    n_cmp++; if (instret6 !== 64'd0) begin n_mis++; $display("FAIL rmt_instret: got %0d want 0", instret6); end
    n_cmp++; if (mepc6 !== 32'h0) begin n_mis++; $display("FAIL rmt_mepc: got 0x%0h want 0x0", mepc6); end
    issue(1'b1, WB_ALU, 5'd3, 32'h3333, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (rf_we6 !== 1'b1 || flush6 !== 1'b0) begin n_mis++; $display("FAIL rmt_run: got we=%0b flush=%0b want we=1 flush=0", rf_we6, flush6); end
    exp_instret++;
    tick(32'h0, 1'b0);
    n_cmp++; if (instret6 !== exp_instret) begin n_mis++; $display("FAIL rmt_instret_after: got %0d want %0d", instret6, exp_instret); end
  endtask

  task test_instret_wrap();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(32'h0, 1'b0);
    release dut.instret_q;
    #1;
    n_cmp++; if (instret6 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_mis++; $display("FAIL wrap_preload: got 0x%0h want all ones", instret6); end
    issue(1'b1, WB_ALU, 5'd4, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick(32'h0, 1'b0);
    n_cmp++; if (instret6 !== 64'd0) begin n_mis++; $display("FAIL wrap_zero: got 0x%0h want 0x0", instret6); end
  endtask

  initial begin
    rst = 1'b1;
    idle5();
    mem_out6 = 32'h0;
    addr_misaligned6 = 1'b0;
    exp_instret = 64'd0;
    test_reset();
    test_alu_write();
    test_wb_sources();
    test_rd0_links();
    test_load();
    test_back_to_back_trap();
    test_reset_mid_trap();
    test_instret_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
